// File: rtl/div32.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV32_SIGNED_EN for two's-complement division; default build is unsigned-only.
module div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;

`ifdef DIV32_SIGNED_EN
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
`endif

  // Shift one dividend bit into the partial remainder, then trial-subtract
  assign rem_sh = {rem_q, acc_q[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
`ifdef DIV32_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIV32_SIGNED_EN
          negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          negr_d = dividend[WIDTH-1];
          acc_d  = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d  = divisor[WIDTH-1] ? -divisor : divisor;
`else
          acc_d  = dividend;
          dvs_d  = divisor;
`endif
          if (divisor == '0) begin
            // Keep the raw dividend: it becomes the remainder
            acc_d   = dividend;
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        acc_d = {acc_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dvs_q == '0) begin
          quot_d = '1;
          remd_d = acc_q;
          dbz_d  = 1'b1;
        end else begin
`ifdef DIV32_SIGNED_EN
          quot_d = negq_q ? -acc_q : acc_q;
          remd_d = negr_q ? -rem_q : rem_q;
`else
          quot_d = acc_q;
          remd_d = rem_q;
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIV32_SIGNED_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`endif

  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32.sv
// Directed + scoreboard bench for div32 (latency, handshake, reset, div-by-zero).
module tb_div32;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];

  div32 #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] ma, mb;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
      return e;
    end
`ifdef DIV32_SIGNED_EN
    ma  = a[31] ? -a : a;
    mb  = b[31] ? -b : b;
    e.q = ma / mb;
    e.r = ma % mb;
    if (a[31] ^ b[31]) e.q = -e.q;
    if (a[31]) e.r = -e.r;
`else
    ma  = a;
    mb  = b;
    e.q = ma / mb;
    e.r = ma % mb;
`endif
    e.z = 1'b0;
    return e;
  endfunction

  task automatic push(input logic [31:0] q, input logic [31:0] r,
                      input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_z"}, {31'd0, div_by_zero}, {31'd0, e.z});
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input int lat_exp);
    int lat;
    start_op(a, b);
    wait_done(lat);
    chk({tag, "_lat"}, lat, lat_exp);
    pop_chk(tag);
    tick();
  endtask

  initial begin
    int lat;
    int t;
    int n;
    int last;
    int idle_lo;
    int dones;
    logic changed;
    exp_t e;
    logic [31:0] a, b;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 100 / 7 with handshake checks
    push(32'd14, 32'd2, 1'b0);
    start_op(32'd100, 32'd7);
    chk("busy_c1", {31'd0, busy}, 32'd1);
    chk("q_hold_c1", quotient, 32'd0);
    wait_done(lat);
    chk("d100_lat", lat, 34);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    pop_chk("d100");
    tick();
    chk("done_pulse", {31'd0, done}, 32'd0);

`ifdef DIV32_SIGNED_EN
    push(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run("neg100", 32'hFFFF_FF9C, 32'd7, 34);
    push(32'h8000_0000, 32'd0, 1'b0);
    run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 34);
    push(32'hFFFF_FFFD, 32'd1, 1'b0);
    run("pos_neg", 32'd7, 32'hFFFF_FFFE, 34);
`else
    push(32'h2492_4916, 32'd2, 1'b0);
    run("neg100", 32'hFFFF_FF9C, 32'd7, 34);
    push(32'd0, 32'h8000_0000, 1'b0);
    run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 34);
    push(32'd1, 32'd0, 1'b0);
    run("big_eq", 32'hF000_0001, 32'hF000_0001, 34);
`endif

    push(32'hFFFF_FFFF, 32'd5, 1'b1);
    run("dbz", 32'd5, 32'd0, 2);
    push(32'd3, 32'd0, 1'b0);
    run("after_dbz", 32'd9, 32'd3, 34);

    // Start pulse mid-run must be ignored
    push(32'd14, 32'd2, 1'b0);
    start_op(32'd100, 32'd7);
    t = 1;
    changed = 1'b0;
    dones = 0;
    while (t < 45) begin
      if (t == 10) begin
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        chk("ign_lat", t, 34);
        pop_chk("ign");
      end else if (t < 34) begin
        if (quotient !== 32'd3 || remainder !== 32'd0) changed = 1'b1;
      end
      tick();
      t++;
    end
    chk("ign_stable", {31'd0, changed}, 32'd0);
    chk("ign_dones", dones, 1);

    // Reset during a run aborts it
    start_op(32'd100, 32'd7);
    for (int i = 1; i < 15; i++) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      tick();
    end
    chk("rst_no_done", dones, 0);
    push(32'hFFFF_FFFF, 32'd0, 1'b0);
    run("after_rst", 32'hFFFF_FFFF, 32'd1, 34);

    // Random operands against the model
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      e = model(a, b);
      sb.push_back(e);
      run("rand", a, b, 34);
    end

    // Start held high: one result every 35 cycles
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    push(32'd14, 32'd2, 1'b0);
    tick();
    t = 1;
    n = 0;
    last = 0;
    idle_lo = 0;
    while (n < 3 && t < 300) begin
      if (done) begin
        if (n == 0) chk("held_lat", t, 34);
        else chk("held_period", t - last, 35);
        pop_chk("held");
        last = t;
        n++;
        if (n < 3) push(32'd14, 32'd2, 1'b0);
        else start = 1'b0;
      end else if (!busy && n > 0) begin
        idle_lo++;
      end
      tick();
      t++;
    end
    chk("held_count", n, 3);
    chk("held_idle_lo", idle_lo, 2);
    tick();
    tick();
    chk("held_end_idle", {31'd0, busy}, 32'd0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
